serial_add_ctrl: RTL

//   Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in and

---
 rtl/serial_add_ctrl_pkg.sv | 18 +
 rtl/serial_add_ctrl_full_adder.sv | 21 ++
 rtl/serial_add_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_pkg
//   Shared definitions for the bit-serial adder controller.
//   It holds the controller state encoding (ST_IDLE, ST_RUN, ST_DONE) and the
//   default sizing parameters.
// -----------------------------------------------------------------------------
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full adder. It is the entire arithmetic datapath of the serial adder.
// Ports:
//   a, b  in   operand bits
//   cin   in   carry in
//   sum   out  a ^ b ^ cin
//   cout  out  majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller. It accepts two WIDTH-bit operands and a
//   carry-in through a valid/ready handshake. It adds them LSB-first, one bit
//   per clock, through a single full_adder. It presents {out_cout, out_sum} on
//   a valid/ready output handshake.
//
//   Optional build macro: SERIAL_ADD_SUB_EN
//     When this macro is defined, the block has an extra in_sub input. If
//     in_sub is 1 at accept, the block computes in_a - in_b. In that case
//     out_cout is NOT borrow.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand set valid
//   in_ready   out  high only in IDLE
//   in_a/in_b  in   WIDTH-bit operands
//   in_cin     in   carry into bit 0
//   in_sub     in   subtract select (only with SERIAL_ADD_SUB_EN)
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   out_sum    out  WIDTH-bit sum
//   out_cout   out  carry out of the MSB
//   busy       out  high in RUN or DONE
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for operands, in_ready=1
// RUN    | one bit added per cycle, count = index of current bit
// DONE   | result held, out_valid=1 until out_ready
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic [CNT_W-1:0] count_q;

  logic             accept;
  logic             step;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

  // Subtraction is a + ~b + 1. Only the load values change, so the serial
  // datapath is the same in both builds.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load   = in_sub ? ~in_b : in_b;
  assign cin_load = in_sub ? 1'b1  : in_cin;
`else
  assign b_load   = in_b;
  assign cin_load = in_cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        // The last bit is added in the same cycle that the state moves to DONE.
        if (count_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else if (accept) begin
      a_sr    <= in_a;
      b_sr    <= b_load;
      sum_sr  <= '0;
      carry_q <= cin_load;
      count_q <= '0;
    end else if (step) begin
      sum_sr  <= {fa_sum, sum_sr[WIDTH-1:1]};
      carry_q <= fa_cout;
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      if (count_q != CNT_MAX) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_sum   = sum_sr;
  assign out_cout  = carry_q;

endmodule
